bht_sweep_predictor: RTL and testbench
======================================

// Module: bht_sweep_predictor
// PURPOSE
//  - 2-bit saturating branch history table for the cv32a65x frontend (BHTEntries=1024, BranchPredictorImpl=1).
//  - Sits between fetch address generation (lookup) and the branch unit (resolve/update).
//  - Storage is a RAM-friendly table without reset (FpgaEn=1): a sweep FSM clears it after reset and flush.
// PARAMETERS
//  NR_ENTRIES       1024  total 2-bit counters; power of 2
//  INSTR_PER_FETCH  2     counters per row (32-bit fetch, RVC => 2 halfword slots)
//  XLEN             32    address width
//  (derived) ROWS=NR_ENTRIES/INSTR_PER_FETCH=512, ROW_BITS=$clog2(ROWS)=9, COL_BITS=$clog2(INSTR_PER_FETCH)=1
// PORTS
//  clk_i           in   1                 clock
//  rst_i           in   1                 reset, asynchronous, active-high
//  flush_i         in   1                 pulse: invalidate whole table (restarts sweep)
//  busy_o          out  1                 1 while sweep in progress
//  lookup_valid_i  in   1                 lookup request this cycle
//  vpc_i           in   XLEN              fetch address of lookup
//  pred_valid_o    out  INSTR_PER_FETCH   per-slot entry valid, 1 cycle after request
//  pred_taken_o    out  INSTR_PER_FETCH   per-slot prediction (counter MSB)
//  upd_valid_i     in   1                 resolved conditional branch
//  upd_pc_i        in   XLEN              branch PC
//  upd_taken_i     in   1                 actual outcome
// BEHAVIOUR
//  One clock; reset is asynchronous and active-high.
//  Indexing: col = pc[COL_BITS:1], row = pc[ROW_BITS+COL_BITS:COL_BITS+1] (row=pc[10:2], col=pc[1]).
//  Entry = {valid, ctr[1:0]}; prediction taken = ctr[1].
//  FSM states: CLEAR, IDLE.
//   - Reset -> CLEAR, sweep_idx=0. CLEAR writes row sweep_idx with all-zero, idx++ per cycle.
//   - CLEAR with idx==ROWS-1 -> IDLE next cycle (sweep = exactly ROWS=512 cycles, busy_o=1 throughout).
//   - flush_i in any state -> CLEAR, idx=0 (flush during CLEAR restarts the sweep).
//   - Reset mid-sweep restarts the sweep from idx 0.
//  Reset values: busy_o=1, pred_valid_o=0, pred_taken_o=0, update pipe valids=0.
//  Lookup: registered read, latency 1.
//   - In CLEAR (or if flush_i is high on the request cycle): pred_valid_o=0 and pred_taken_o=0 next cycle.
//   - No request: outputs go 0 next cycle.
//   - Read-first: a lookup of a row written in the same cycle returns the pre-write value.
//  Update: 2-stage read-modify-write.
//   - U1 latches {row,col,taken} and reads the row.
//   - U2 computes the new entry and writes one column.
//   - If old valid==0: new={1, taken?2'b10:2'b01}.
//   - Else: ctr+1 saturating at 2'b11 if taken, ctr-1 saturating at 2'b00 if not; valid stays 1.
//   - Bypass: if U2 writes the same row+col that U1 holds, U1 uses the U2 write data, not the RAM data.
//     Back-to-back updates to one entry therefore accumulate.
//   - Updates arriving in CLEAR are dropped. flush_i kills U1 and U2 in that cycle (flush wins; no write).
//   - Sweep write and U2 write never coincide, because U2 is only live in IDLE.
//  One lookup and one update accepted per cycle; no backpressure (no ready signals).
// TESTING
//  1 reset release -> busy_o=1 for exactly 512 cycles; lookup of every row during/after -> pred_valid_o=0.
//  2 upd pc=0x100 taken x1 -> lookup 0x100 gives valid[0]=1 taken[0]=1 (ctr 10); lookup 0x102 slot1 valid=0.
//  3 upd pc=0x104 not-taken x3 back-to-back -> ctr 01->00->00; lookup 0x104 taken=0, valid=1.
//  4 upd pc=0x200 taken x4 consecutive cycles -> ctr 10,11,11,11 (bypass); then 2x not-taken -> 01, predict not-taken.
//  5 flush_i at sweep idx 300 -> sweep restarts, busy_o stays 1 for 512 more cycles; prior entries read invalid.
//  6 lookup 0x300 same cycle as U2 write to 0x300 -> old value returned; lookup next cycle -> new value.

Source files
------------

// File: rtl/bht_sweep_predictor.sv
// bht_sweep_predictor: 2-bit saturating BHT with non-reset RAM storage cleared by a sweep FSM after reset/flush.
module bht_sweep_predictor #(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned XLEN            = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  output logic                       busy_o,
  input  logic                       lookup_valid_i,
  input  logic [XLEN-1:0]            vpc_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  input  logic                       upd_valid_i,
  input  logic [XLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i
);
  localparam int unsigned ROWS     = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS = $clog2(ROWS);
  localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned RHI      = ROW_BITS + COL_BITS;

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e                              state_q, state_d;
  logic [ROW_BITS-1:0]                 idx_q, idx_d;
  logic [INSTR_PER_FETCH-1:0][2:0]     mem [ROWS];
  logic [INSTR_PER_FETCH-1:0][2:0]     rd_q;
  logic                                lk_q, lk_d;
  logic                                u1_v_q, u1_v_d, u1_tk_q;
  logic [ROW_BITS-1:0]                 u1_row_q, u2_row_q;
  logic [COL_BITS-1:0]                 u1_col_q, u2_col_q;
  logic                                u2_v_q, u2_v_d;
  logic [2:0]                          u2_data_q, u1_old, u1_new;
  logic                                accept;
  logic                                unused_ok;

  assign busy_o = state_q == CLEAR;
  assign accept = state_q == IDLE && !flush_i;
  assign lk_d   = lookup_valid_i && accept;
  assign u1_v_d = upd_valid_i && accept;
  assign u2_v_d = u1_v_q && !flush_i;

  always_comb begin
    state_d = flush_i ? CLEAR : (state_q == CLEAR && idx_q == ROW_BITS'(ROWS - 1)) ? IDLE : state_q;
    idx_d   = (flush_i || state_q == IDLE) ? '0 : idx_q + 1'b1;
  end

  // U2 data is not yet in the RAM while U1 reads, so forward it for the same entry
  always_comb begin
    u1_old = (u2_v_q && u2_row_q == u1_row_q && u2_col_q == u1_col_q) ? u2_data_q
                                                                       : mem[u1_row_q][u1_col_q];
    u1_new = !u1_old[2] ? {1'b1, u1_tk_q ? 2'b10 : 2'b01}
           : u1_tk_q    ? {1'b1, u1_old[1:0] == 2'b11 ? 2'b11 : u1_old[1:0] + 2'b01}
                        : {1'b1, u1_old[1:0] == 2'b00 ? 2'b00 : u1_old[1:0] - 2'b01};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      lk_q      <= 1'b0;
      u1_v_q    <= 1'b0;
      u1_tk_q   <= 1'b0;
      u1_row_q  <= '0;
      u1_col_q  <= '0;
      u2_v_q    <= 1'b0;
      u2_row_q  <= '0;
      u2_col_q  <= '0;
      u2_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lk_q      <= lk_d;
      u1_v_q    <= u1_v_d;
      u1_tk_q   <= upd_taken_i;
      u1_row_q  <= upd_pc_i[RHI:COL_BITS+1];
      u1_col_q  <= upd_pc_i[COL_BITS:1];
      u2_v_q    <= u2_v_d;
      u2_row_q  <= u1_row_q;
      u2_col_q  <= u1_col_q;
      u2_data_q <= u1_new;
    end
  end

  // Storage has no reset so it maps onto block/distributed RAM
  always_ff @(posedge clk_i) begin
    rd_q <= mem[vpc_i[RHI:COL_BITS+1]];
    if (state_q == CLEAR)
      mem[idx_q] <= '0;
    else if (u2_v_q && !flush_i)
      mem[u2_row_q][u2_col_q] <= u2_data_q;
  end

  for (genvar g = 0; g < INSTR_PER_FETCH; g++) begin : g_out
    assign pred_valid_o[g] = lk_q & rd_q[g][2];
    assign pred_taken_o[g] = lk_q & rd_q[g][1];
  end

  assign unused_ok = ^{vpc_i[XLEN-1:RHI+1], vpc_i[0], upd_pc_i[XLEN-1:RHI+1], upd_pc_i[0], rd_q};
endmodule

// File: tb/tb_bht_sweep_predictor.sv
// tb_bht_sweep_predictor: scoreboard bench for the sweep-cleared branch history table.
module tb_bht_sweep_predictor;
  logic        clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
  logic        lookup_valid_i = 1'b0, upd_valid_i = 1'b0, upd_taken_i = 1'b0;
  logic [31:0] vpc_i = '0, upd_pc_i = '0;
  logic        busy_o;
  logic [1:0]  pv, pt;
  logic [3:0]  sb [$];
  int          n_tests = 0, n_fail = 0;

  bht_sweep_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .busy_o(busy_o),
    .lookup_valid_i(lookup_valid_i), .vpc_i(vpc_i),
    .pred_valid_o(pv), .pred_taken_o(pt),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected value encoding: {valid[1], valid[0], taken[1], taken[0]}
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (lookup_valid_i) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL lookup: scoreboard empty");
      end else check($sformatf("lookup_%0h", vpc_i), {pv, pt}, sb.pop_front());
    end
  endtask

  task automatic drive(input logic lv, input logic [31:0] va, input logic uv, input logic [31:0] ua,
                       input logic ut, input logic fl, input logic [3:0] e);
    lookup_valid_i = lv;
    vpc_i          = va;
    upd_valid_i    = uv;
    upd_pc_i       = ua;
    upd_taken_i    = ut;
    flush_i        = fl;
    if (lv) sb.push_back(e);
    tick();
  endtask

  task automatic look(input logic [31:0] a, input logic [3:0] e);
    drive(1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0, e);
  endtask

  task automatic upd(input logic [31:0] a, input logic t);
    drive(1'b0, 32'h0, 1'b1, a, t, 1'b0, 4'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
  endtask

  // lookups during the sweep must read invalid; an update is injected late in the sweep and must be dropped
  task automatic wait_sweep(input string tag, input bit inj);
    int n = 0;
    while (busy_o && n < 1000) begin
      drive(1'b1, $urandom, inj && n == 490, 32'h500, 1'b1, 1'b0, 4'h0);
      n++;
    end
    check(tag, n, 512);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", {31'h0, busy_o}, 1);
    check("rst_pred", {pv, pt}, 0);
    rst_i = 1'b0;
    idle(100);
    rst_i = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, busy_o}, 1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    wait_sweep("sweep_len_rst", 1'b0);
    look(32'h0, 4'b0000);
    look(32'h7fc, 4'b0000);
    look(32'h100, 4'b0000);

    upd(32'h100, 1'b1);
    idle(3);
    look(32'h100, 4'b0101);
    look(32'h102, 4'b0101);

    upd(32'h104, 1'b0);
    upd(32'h104, 1'b0);
    upd(32'h104, 1'b0);
    idle(3);
    look(32'h104, 4'b0100);
    upd(32'h104, 1'b1);
    idle(3);
    look(32'h104, 4'b0100);
    upd(32'h104, 1'b1);
    idle(3);
    look(32'h104, 4'b0101);

    repeat (4) upd(32'h200, 1'b1);
    idle(3);
    look(32'h200, 4'b0101);
    repeat (2) upd(32'h200, 1'b0);
    idle(3);
    look(32'h200, 4'b0100);
    upd(32'h202, 1'b1);
    idle(3);
    look(32'h200, 4'b1110);

    upd(32'h300, 1'b1);
    idle(1);
    look(32'h300, 4'b0000);
    look(32'h300, 4'b0101);
    idle(1);
    check("noreq_pred", {pv, pt}, 0);

    drive(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 4'b0000);
    check("flush_busy", {31'h0, busy_o}, 1);
    idle(300);
    drive(1'b1, 32'h104, 1'b1, 32'h104, 1'b1, 1'b1, 4'b0000);
    wait_sweep("sweep_len_flush", 1'b1);
    look(32'h100, 4'b0000);
    look(32'h104, 4'b0000);
    look(32'h200, 4'b0000);
    look(32'h300, 4'b0000);
    look(32'h500, 4'b0000);
    upd(32'h500, 1'b0);
    idle(3);
    look(32'h500, 4'b0100);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
